vram_b_arbiter: RTL and testbench

VRAM_B_ARBITER -- requirements
Module: vram_b_arbiter

---
 rtl/vram_b_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vram_b_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_b_arbiter.sv
// Port-B arbiter for a shared 1K x 16 video RAM: video word reads compete with
// CPU byte reads and atomic byte writes (read-modify-write), with CPU starvation guard.
module vram_b_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [9:0]  vid_addr,
    output logic        vid_ack,
    output logic        vid_rvalid,
    output logic [15:0] vid_rdata,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic [1:0]  ram_dip,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VRD,
        S_CRD,
        S_CWAIT,
        S_CWR
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

    function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic hi,
                                               input logic [7:0] b);
        return hi ? {b, word[7:0]} : {word[15:8], b};
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        vid_rvalid_q;

    // CPU access attributes captured at grant time
    logic        hi_q;
    logic        wr_q;
    logic [7:0]  wdata_q;
    logic        cpu_grant;

    logic        cpu_ok;
    assign cpu_ok = cpu_req && !cpu_ack_q;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        cpu_grant   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!cpu_req) begin
                    starve_d = '0;
                end
                if (cpu_ok && (starve_q == LIMIT || !vid_req)) begin
                    state_d    = S_CRD;
                    ram_en_d   = 1'b1;
                    ram_addr_d = cpu_addr[10:1];
                    starve_d   = '0;
                    cpu_grant  = 1'b1;
                end else if (vid_req) begin
                    state_d    = S_VRD;
                    ram_en_d   = 1'b1;
                    ram_addr_d = vid_addr;
                    if (cpu_req && starve_q < LIMIT) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            S_VRD: begin
                state_d = S_IDLE;
            end
            S_CRD: begin
                state_d = S_CWAIT;
            end
            S_CWAIT: begin
                // ram_rdata now holds the word addressed in CRD
                cpu_ack_d = 1'b1;
                if (wr_q) begin
                    state_d     = S_CWR;
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = merge_byte(ram_rdata, hi_q, wdata_q);
                end else begin
                    state_d     = S_IDLE;
                    cpu_rdata_d = sel_byte(ram_rdata, hi_q);
                end
            end
            S_CWR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rvalid_q <= (state_q == S_VRD);
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_grant) begin
            hi_q    <= cpu_addr[0];
            wr_q    <= cpu_wr;
            wdata_q <= cpu_wdata;
        end
    end

    assign vid_ack    = (state_q == S_VRD);
    assign vid_rvalid = vid_rvalid_q;
    assign vid_rdata  = ram_rdata;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_dip    = 2'b00;

endmodule

// File: tb/tb_vram_b_arbiter.sv
// Directed bench for vram_b_arbiter with a behavioural synchronous RAM on port B.
module tb_vram_b_arbiter;

    logic        clk;
    logic        reset;
    logic        vid_req;
    logic [9:0]  vid_addr;
    logic        vid_ack;
    logic        vid_rvalid;
    logic [15:0] vid_rdata;
    logic        cpu_req;
    logic        cpu_wr;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [1:0]  ram_dip;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [15:0] pre_data;

    int n_checks;
    int n_fail;

    vram_b_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_dip    (ram_dip),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAM, plus a bench-side preload path
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    int exp_vack [13] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0};
    int exp_cack [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        int nv;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        vid_req   = 1'b0;
        vid_addr  = '0;
        cpu_req   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        ram_rdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_ram_en",    32'(ram_en),     32'h0);
        chk("rst_ram_we",    32'(ram_we),     32'h0);
        chk("rst_ram_addr",  32'(ram_addr),   32'h0);
        chk("rst_ram_wdata", 32'(ram_wdata),  32'h0);
        chk("rst_cpu_ack",   32'(cpu_ack),    32'h0);
        chk("rst_vid_ack",   32'(vid_ack),    32'h0);
        chk("rst_vid_rv",    32'(vid_rvalid), 32'h0);
        chk("rst_dip",       32'(ram_dip),    32'h0);

        preload(10'h155, 16'hBEEF);
        preload(10'h010, 16'h1234);
        preload(10'h000, 16'h1111);
        preload(10'h001, 16'h2222);
        preload(10'h002, 16'h3333);
        reset = 1'b0;

        // CPU read of the high byte of word 0x155
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h2AB;
        @(negedge clk);
        chk("rd_crd_en",   32'(ram_en),   32'h1);
        chk("rd_crd_we",   32'(ram_we),   32'h0);
        chk("rd_crd_addr", 32'(ram_addr), 32'h155);
        chk("rd_crd_ack",  32'(cpu_ack),  32'h0);
        @(negedge clk);
        chk("rd_wait_en",  32'(ram_en),   32'h0);
        chk("rd_wait_ack", 32'(cpu_ack),  32'h0);
        @(negedge clk);
        chk("rd_ack",      32'(cpu_ack),   32'h1);
        chk("rd_data",     32'(cpu_rdata), 32'hBE);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_ack_pulse", 32'(cpu_ack),   32'h0);
        chk("rd_data_hold", 32'(cpu_rdata), 32'hBE);

        // CPU write of the low byte of word 0x010
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h020; cpu_wdata = 8'hAB;
        @(negedge clk);
        chk("wr_crd_en",   32'(ram_en),   32'h1);
        chk("wr_crd_we",   32'(ram_we),   32'h0);
        chk("wr_crd_addr", 32'(ram_addr), 32'h010);
        @(negedge clk);
        chk("wr_wait_en",  32'(ram_en),   32'h0);
        @(negedge clk);
        chk("wr_cwr_en",    32'(ram_en),    32'h1);
        chk("wr_cwr_we",    32'(ram_we),    32'h1);
        chk("wr_cwr_addr",  32'(ram_addr),  32'h010);
        chk("wr_cwr_wdata", 32'(ram_wdata), 32'h12AB);
        chk("wr_cwr_ack",   32'(cpu_ack),   32'h1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("wr_after_we",    32'(ram_we),    32'h0);
        chk("wr_after_ack",   32'(cpu_ack),   32'h0);
        chk("wr_wdata_hold",  32'(ram_wdata), 32'h12AB);
        chk("wr_mem_lo",      32'(mem[10'h010]), 32'h12AB);

        // High-byte write on the same word
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h021; cpu_wdata = 8'hCD;
        repeat (3) @(negedge clk);
        chk("wrhi_wdata", 32'(ram_wdata), 32'hCDAB);
        chk("wrhi_ack",   32'(cpu_ack),   32'h1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("wrhi_mem",   32'(mem[10'h010]), 32'hCDAB);

        // Video burst over words 0,1,2
        vid_req = 1'b1; vid_addr = 10'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("vb_ack%0d", i),  32'(vid_ack),  32'h1);
            chk($sformatf("vb_addr%0d", i), 32'(ram_addr), 32'(i));
            chk($sformatf("vb_en%0d", i),   32'(ram_en),   32'h1);
            if (i == 2) vid_req = 1'b0;
            else        vid_addr = 10'(i + 1);
            @(negedge clk);
            chk($sformatf("vb_noack%0d", i), 32'(vid_ack),    32'h0);
            chk($sformatf("vb_rv%0d", i),    32'(vid_rvalid), 32'h1);
            chk($sformatf("vb_data%0d", i),  32'(vid_rdata),  32'(16'h1111 * (i + 1)));
        end
        @(negedge clk);
        chk("vb_rv_end", 32'(vid_rvalid), 32'h0);

        // Both requesters busy: four video grants, then the CPU is forced in
        nv = 0;
        vid_req = 1'b1; vid_addr = 10'h100;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h2AB;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("st_vack%0d", i), 32'(vid_ack), 32'(exp_vack[i]));
            chk($sformatf("st_cack%0d", i), 32'(cpu_ack), 32'(exp_cack[i]));
            if (vid_ack && i < 10) nv++;
            if (vid_ack) vid_addr = vid_addr + 10'd1;
            if (i == 8) chk("st_cpu_addr", 32'(ram_addr), 32'h155);
            if (i == 10) begin
                chk("st_cpu_data", 32'(cpu_rdata), 32'hBE);
                cpu_req = 1'b0;
            end
            if (i == 11) vid_req = 1'b0;
        end
        chk("st_nvid", 32'(nv), 32'd4);

        // Video request arriving during a CPU write must wait for CWR to finish
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h020; cpu_wdata = 8'h55;
        @(negedge clk);
        chk("at_crd_vack", 32'(vid_ack), 32'h0);
        vid_req = 1'b1; vid_addr = 10'd5;
        @(negedge clk);
        chk("at_wait_vack", 32'(vid_ack), 32'h0);
        chk("at_wait_en",   32'(ram_en),  32'h0);
        @(negedge clk);
        chk("at_cwr_vack",  32'(vid_ack),   32'h0);
        chk("at_cwr_we",    32'(ram_we),    32'h1);
        chk("at_cwr_wdata", 32'(ram_wdata), 32'hCD55);
        chk("at_cwr_cack",  32'(cpu_ack),   32'h1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("at_idle_vack", 32'(vid_ack), 32'h0);
        chk("at_idle_en",   32'(ram_en),  32'h0);
        @(negedge clk);
        chk("at_vrd_vack",  32'(vid_ack),  32'h1);
        chk("at_vrd_addr",  32'(ram_addr), 32'h005);
        chk("at_vrd_we",    32'(ram_we),   32'h0);
        vid_req = 1'b0;
        @(negedge clk);
        chk("at_mem", 32'(mem[10'h010]), 32'hCD55);

        // Reset in CWAIT of a write aborts it
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h021; cpu_wdata = 8'h99;
        @(negedge clk);
        chk("rw_crd_en", 32'(ram_en), 32'h1);
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("rw_en",    32'(ram_en),    32'h0);
        chk("rw_we",    32'(ram_we),    32'h0);
        chk("rw_addr",  32'(ram_addr),  32'h0);
        chk("rw_wdata", 32'(ram_wdata), 32'h0);
        chk("rw_crd",   32'(cpu_rdata), 32'h0);
        chk("rw_cack",  32'(cpu_ack),   32'h0);
        @(negedge clk);
        chk("rw_cack2", 32'(cpu_ack), 32'h0);
        chk("rw_we2",   32'(ram_we),  32'h0);
        vid_req = 1'b1; vid_addr = 10'd7; reset = 1'b0;
        @(negedge clk);
        chk("rw_first_vack", 32'(vid_ack),  32'h1);
        chk("rw_first_addr", 32'(ram_addr), 32'h007);
        chk("rw_cack3",      32'(cpu_ack),  32'h0);
        vid_req = 1'b0;
        @(negedge clk);
        chk("rw_mem",  32'(mem[10'h010]), 32'hCD55);
        chk("rw_cack4", 32'(cpu_ack), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
